// File: rtl/comp_seq_ctrl.sv
// Wide equality compare sequenced through one shared 4-bit equality slice, LSB nibble first.
// Latency: NIB+1 cycles from accepted start to done (m+2 on early exit at nibble m).
// Backpressure: start is accepted only in IDLE; requests while busy are dropped, not queued.
module comp_seq_ctrl #(
   parameter int WIDTH      = 16,
   parameter bit EARLY_EXIT = 1'b1,
   localparam int NIB = WIDTH / 4,
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [3:0]       slice_a,
   output logic [3:0]       slice_b,
   input  logic             slice_eq,
   output logic             busy,
   output logic             done,
   output logic             a_eq_b,
   output logic [IW-1:0]    mism_idx
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [IW-1:0]    cnt_q, cnt_d;
   logic             mis_seen_q, mis_seen_d;
   logic             run_eq_q, run_eq_d;
   logic [IW-1:0]    mis_idx_q, mis_idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             a_eq_b_q, a_eq_b_d;
   logic [IW-1:0]    mism_idx_q, mism_idx_d;
   logic             last_nib;
   logic             nib_mis;

   assign last_nib = (cnt_q == IW'(NIB - 1));
   assign nib_mis  = ~slice_eq;

   // Next-state and datapath: load on start, shift one nibble per CMP cycle, publish result on exit.
   always_comb begin
      state_d    = state_q;
      a_sh_d     = a_sh_q;
      b_sh_d     = b_sh_q;
      cnt_d      = cnt_q;
      mis_seen_d = mis_seen_q;
      run_eq_d   = run_eq_q;
      mis_idx_d  = mis_idx_q;
      done_d     = 1'b0;
      a_eq_b_d   = a_eq_b_q;
      mism_idx_d = mism_idx_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d     = a;
               b_sh_d     = b;
               cnt_d      = '0;
               mis_seen_d = 1'b0;
               run_eq_d   = 1'b1;
               mis_idx_d  = '0;
               state_d    = CMP;
            end
         end
         CMP: begin
            a_sh_d = a_sh_q >> 4;
            b_sh_d = b_sh_q >> 4;
            cnt_d  = cnt_q + IW'(1);
            // Only the lowest mismatching nibble is recorded, even on a full scan.
            if (nib_mis && !mis_seen_q) begin
               mis_seen_d = 1'b1;
               run_eq_d   = 1'b0;
               mis_idx_d  = cnt_q;
            end
            if (last_nib || (EARLY_EXIT && nib_mis)) begin
               state_d    = DONE;
               done_d     = 1'b1;
               a_eq_b_d   = run_eq_d;
               mism_idx_d = mis_idx_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset aborts any compare in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         cnt_q      <= '0;
         mis_seen_q <= 1'b0;
         run_eq_q   <= 1'b0;
         mis_idx_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         a_eq_b_q   <= 1'b0;
         mism_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         a_sh_q     <= a_sh_d;
         b_sh_q     <= b_sh_d;
         cnt_q      <= cnt_d;
         mis_seen_q <= mis_seen_d;
         run_eq_q   <= run_eq_d;
         mis_idx_q  <= mis_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         a_eq_b_q   <= a_eq_b_d;
         mism_idx_q <= mism_idx_d;
      end
   end

   assign slice_a  = (state_q == CMP) ? a_sh_q[3:0] : 4'h0;
   assign slice_b  = (state_q == CMP) ? b_sh_q[3:0] : 4'h0;
   assign busy     = busy_q;
   assign done     = done_q;
   assign a_eq_b   = a_eq_b_q;
   assign mism_idx = mism_idx_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Bench for comp_seq_ctrl: one instance with early exit, one with full scan, sharing stimulus.
// Each test task drives its scenario and checks observations against a nibble-level model.
// The 4-bit equality slice is modelled as a plain combinational compare.
module tb_comp_seq_ctrl;

   localparam int W   = 16;
   localparam int NIB = W / 4;
   localparam int WIN = NIB + 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;

   logic [3:0]    slice_a1, slice_b1, slice_a0, slice_b0;
   logic          slice_eq1, slice_eq0;
   logic          busy1, done1, a_eq_b1, busy0, done0, a_eq_b0;
   logic [1:0]    mism1, mism0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign slice_eq1 = (slice_a1 == slice_b1);
   assign slice_eq0 = (slice_a0 == slice_b0);

   comp_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .slice_a(slice_a1), .slice_b(slice_b1), .slice_eq(slice_eq1),
      .busy(busy1), .done(done1), .a_eq_b(a_eq_b1), .mism_idx(mism1));

   comp_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .slice_a(slice_a0), .slice_b(slice_b0), .slice_eq(slice_eq0),
      .busy(busy0), .done(done0), .a_eq_b(a_eq_b0), .mism_idx(mism0));

   // Lowest nibble index where the words differ, -1 if equal.
   function automatic int first_mis(input logic [W-1:0] x, input logic [W-1:0] y);
      for (int i = 0; i < NIB; i++)
         if (x[i*4 +: 4] != y[i*4 +: 4]) return i;
      return -1;
   endfunction

   // Start-to-done latency in cycles for the given operands and exit mode.
   function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit early);
      int m;
      m = first_mis(x, y);
      if (early && m >= 0) return m + 2;
      return NIB + 1;
   endfunction

   // Issue one single-cycle start and record what both instances do over cycles 1..WIN.
   task automatic run_one(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int dc1, output int dn1, output int eq1, output int mi1, output int bc1,
                          output int dc0, output int dn0, output int eq0, output int mi0, output int bc0,
                          output logic [4*(WIN+1)-1:0] sa_seq, output logic [4*(WIN+1)-1:0] sb_seq);
      dc1 = -1; dn1 = 0; eq1 = -1; mi1 = -1; bc1 = 0;
      dc0 = -1; dn0 = 0; eq0 = -1; mi0 = -1; bc0 = 0;
      sa_seq = '0; sb_seq = '0;
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= WIN; c++) begin
         sa_seq[c*4 +: 4] = slice_a1;
         sb_seq[c*4 +: 4] = slice_b1;
         if (busy1) bc1++;
         if (busy0) bc0++;
         if (done1) begin
            dn1++;
            if (dc1 < 0) begin dc1 = c; eq1 = int'(a_eq_b1); mi1 = int'(mism1); end
         end
         if (done0) begin
            dn0++;
            if (dc0 < 0) begin dc0 = c; eq0 = int'(a_eq_b0); mi0 = int'(mism0); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      n_vec++;
      if ({slice_a1, slice_b1, busy1, done1, a_eq_b1, mism1} !== 15'd0) begin
         n_err++;
         $display("FAIL reset_outs_ee got=%h want=0", {slice_a1, slice_b1, busy1, done1, a_eq_b1, mism1});
      end
      n_vec++;
      if ({slice_a0, slice_b0, busy0, done0, a_eq_b0, mism0} !== 15'd0) begin
         n_err++;
         $display("FAIL reset_outs_fs got=%h want=0", {slice_a0, slice_b0, busy0, done0, a_eq_b0, mism0});
      end
   endtask

   task automatic test_equal();
      int dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0;
      logic [4*(WIN+1)-1:0] sa, sb;
      logic [23:0] want_sa;
      want_sa = 24'h0A5C30;  // nibbles for cycles 0..5: -,3,C,5,A,0
      run_one(16'hA5C3, 16'hA5C3, dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0, sa, sb);
      n_vec++;
      if (sa[23:4] !== want_sa[23:4]) begin
         n_err++; $display("FAIL equal_slice_seq got=%h want=%h", sa[23:4], want_sa[23:4]);
      end
      n_vec++;
      if (dc1 !== 5 || dn1 !== 1 || eq1 !== 1 || mi1 !== 0) begin
         n_err++; $display("FAIL equal_done_ee cyc=%0d n=%0d eq=%0d idx=%0d want 5 1 1 0", dc1, dn1, eq1, mi1);
      end
      n_vec++;
      if (dc0 !== 5 || dn0 !== 1 || eq0 !== 1 || mi0 !== 0) begin
         n_err++; $display("FAIL equal_done_fs cyc=%0d n=%0d eq=%0d idx=%0d want 5 1 1 0", dc0, dn0, eq0, mi0);
      end
      n_vec++;
      if (bc1 !== 5 || bc0 !== 5) begin
         n_err++; $display("FAIL equal_busy got=%0d/%0d want=5/5", bc1, bc0);
      end
   endtask

   task automatic test_early_exit();
      int dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0;
      logic [4*(WIN+1)-1:0] sa, sb;
      run_one(16'h1234, 16'h1334, dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0, sa, sb);
      n_vec++;
      if (dc1 !== 4 || dn1 !== 1 || eq1 !== 0 || mi1 !== 2) begin
         n_err++; $display("FAIL early_done cyc=%0d n=%0d eq=%0d idx=%0d want 4 1 0 2", dc1, dn1, eq1, mi1);
      end
      n_vec++;
      if (sa[16 +: 12] !== 12'h0 || sb[16 +: 12] !== 12'h0) begin
         n_err++; $display("FAIL early_slice_zero got=%h/%h want=0/0", sa[16 +: 12], sb[16 +: 12]);
      end
      n_vec++;
      if (bc1 !== 4) begin
         n_err++; $display("FAIL early_busy got=%0d want=4", bc1);
      end
      n_vec++;
      if (dc0 !== 5 || eq0 !== 0 || mi0 !== 2) begin
         n_err++; $display("FAIL early_fullscan cyc=%0d eq=%0d idx=%0d want 5 0 2", dc0, eq0, mi0);
      end
   endtask

   task automatic test_full_scan();
      int dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0;
      logic [4*(WIN+1)-1:0] sa, sb;
      run_one(16'h1234, 16'hF334, dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0, sa, sb);
      n_vec++;
      if (dc0 !== 5 || dn0 !== 1 || eq0 !== 0 || mi0 !== 2) begin
         n_err++; $display("FAIL fullscan_done cyc=%0d n=%0d eq=%0d idx=%0d want 5 1 0 2", dc0, dn0, eq0, mi0);
      end
      n_vec++;
      if (dc1 !== 4 || mi1 !== 2) begin
         n_err++; $display("FAIL fullscan_ee cyc=%0d idx=%0d want 4 2", dc1, mi1);
      end
   endtask

   task automatic test_last_nibble();
      int dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0;
      logic [4*(WIN+1)-1:0] sa, sb;
      run_one(16'h0000, 16'hF000, dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0, sa, sb);
      n_vec++;
      if (dc1 !== 5 || eq1 !== 0 || mi1 !== 3 || dc0 !== 5 || eq0 !== 0 || mi0 !== 3) begin
         n_err++;
         $display("FAIL last_nib got ee=%0d/%0d/%0d fs=%0d/%0d/%0d want 5/0/3", dc1, eq1, mi1, dc0, eq0, mi0);
      end
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if (a_eq_b1 !== 1'b0 || mism1 !== 2'd3 || a_eq_b0 !== 1'b0 || mism0 !== 2'd3) begin
         n_err++;
         $display("FAIL last_nib_hold got=%b/%0d %b/%0d want 0/3", a_eq_b1, mism1, a_eq_b0, mism0);
      end
   endtask

   // start held high across two compares; operands change while the first is running.
   task automatic test_back_to_back();
      int d_cyc[$];
      int d_eq[$];
      a = 16'hA5C3; b = 16'hA5C3; start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 20; c++) begin
         if (c == 2) begin a = 16'h0F0F; b = 16'h0F0F; end
         if (c == 12) start = 1'b0;
         if (done1) begin d_cyc.push_back(c); d_eq.push_back(int'(a_eq_b1)); end
         @(posedge clk); #1;
      end
      start = 1'b0;
      n_vec++;
      if (d_cyc.size() !== 2) begin
         n_err++; $display("FAIL b2b_count got=%0d want=2", d_cyc.size());
      end else begin
         n_vec++;
         if (d_cyc[0] !== 5 || d_cyc[1] !== 11 || d_eq[0] !== 1 || d_eq[1] !== 1) begin
            n_err++;
            $display("FAIL b2b_timing got=%0d,%0d eq=%0d,%0d want 5,11 eq 1,1", d_cyc[0], d_cyc[1], d_eq[0], d_eq[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dn;
      int dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0;
      logic [4*(WIN+1)-1:0] sa, sb;
      a = 16'h1111; b = 16'h1111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({slice_a1, slice_b1, busy1, done1, a_eq_b1, mism1, slice_a0, slice_b0, busy0, done0, a_eq_b0, mism0} !== 30'd0) begin
         n_err++; $display("FAIL midreset_outs got=%b %b want=0 0", busy1, busy0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (done1 || done0 || busy1 || busy0) dn++;
      end
      n_vec++;
      if (dn !== 0) begin
         n_err++; $display("FAIL midreset_nodone got=%0d active cycles want=0", dn);
      end
      run_one(16'hFFFF, 16'hFFFF, dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0, sa, sb);
      n_vec++;
      if (dc1 !== NIB + 1 || eq1 !== 1 || dc0 !== NIB + 1 || eq0 !== 1) begin
         n_err++; $display("FAIL midreset_recover got=%0d/%0d eq=%0d/%0d want %0d eq 1", dc1, dc0, eq1, eq0, NIB + 1);
      end
   endtask

   task automatic test_random();
      int dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0;
      logic [4*(WIN+1)-1:0] sa, sb;
      logic [W-1:0] av, bv;
      int m, x_idx, x_eq;
      for (int it = 0; it < 40; it++) begin
         av = W'($urandom);
         bv = av;
         for (int n = 0; n < NIB; n++)
            if ($urandom_range(0, 2) == 0) bv[n*4 +: 4] = 4'($urandom);
         m     = first_mis(av, bv);
         x_eq  = (m < 0) ? 1 : 0;
         x_idx = (m < 0) ? 0 : m;
         run_one(av, bv, dc1, dn1, eq1, mi1, bc1, dc0, dn0, eq0, mi0, bc0, sa, sb);
         n_vec++;
         if (dc1 !== ref_lat(av, bv, 1'b1) || dn1 !== 1 || eq1 !== x_eq || mi1 !== x_idx || bc1 !== dc1) begin
            n_err++;
            $display("FAIL rand_ee a=%h b=%h got cyc=%0d n=%0d eq=%0d idx=%0d busy=%0d want cyc=%0d eq=%0d idx=%0d",
                     av, bv, dc1, dn1, eq1, mi1, bc1, ref_lat(av, bv, 1'b1), x_eq, x_idx);
         end
         n_vec++;
         if (dc0 !== ref_lat(av, bv, 1'b0) || dn0 !== 1 || eq0 !== x_eq || mi0 !== x_idx || bc0 !== NIB + 1) begin
            n_err++;
            $display("FAIL rand_fs a=%h b=%h got cyc=%0d n=%0d eq=%0d idx=%0d busy=%0d want cyc=%0d eq=%0d idx=%0d",
                     av, bv, dc0, dn0, eq0, mi0, bc0, NIB + 1, x_eq, x_idx);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_equal();
      test_early_exit();
      test_full_scan();
      test_last_nibble();
      test_back_to_back();
      repeat (2) @(posedge clk);
      #1;
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout sim did not finish want=finish");
      $fatal(1, "timeout");
   end

endmodule
